fp_to_int64_seq: RTL and testbench

- Iterative converter from an IEEE 754 double (64-bit) to a signed 64-bit two's-complement integer.
- It is the integer-facing exit of the FP datapath: FP results leave the arithmetic units and are turned into integers for the calculator's integer and display paths.
- Default rounding is round-to-nearest-even. Out-of-range inputs and NaN saturate.
- Alignment uses a multi-cycle shifter that moves at most SHIFT_STEP bits per cycle, which trades latency for area.

---
 rtl/fp_to_int64_seq.sv | 204 ++++++++++++++++++++
 tb/tb_fp_to_int64_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_to_int64_seq.sv
// rtl/fp_to_int64_seq.sv - iterative IEEE 754 double to signed 64-bit integer converter (optional macro: FP2INT_ROUND_MODE_EN)
module fp_to_int64_seq #(
  parameter int SHIFT_STEP = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] fp_in,
`ifdef FP2INT_ROUND_MODE_EN
  input  logic [1:0]  rm,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] int_out,
  output logic        flag_invalid,
  output logic        flag_inexact
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [6:0]  STEP    = 7'(SHIFT_STEP);
  localparam logic [63:0] POS_SAT = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NEG_SAT = 64'h8000_0000_0000_0000;
  // Biased exponents of the range boundaries: e=52 and e=63.
  localparam logic [10:0] EXP_E52 = 11'd1075;
  localparam logic [10:0] EXP_E63 = 11'd1086;

  state_t      state;
  logic        sign_q;
  logic [63:0] work_q;
  logic [6:0]  cnt_q;
  logic        guard_q;
  logic        sticky_q;
`ifdef FP2INT_ROUND_MODE_EN
  logic [1:0]  rm_q;
`endif

  // Operand decode, valid while the operand sits on fp_in.
  logic        in_sign;
  logic [10:0] exp_f;
  logic [51:0] frac;
  logic        frac_zero;
  logic [63:0] direct_mag;
  logic [10:0] right_dist;
  logic [6:0]  cnt_load;

  // Per-cycle alignment step.
  logic [6:0]  shift_k;
  logic [63:0] out_mask;
  logic [63:0] shift_work;
  logic        shift_guard;
  logic        shift_sticky;

  // Rounding and final sign application.
  logic        round_inc;
  logic [63:0] round_mag;
  logic [63:0] round_res;

  // Split the double into fields and precompute both normal-path loads.
  always_comb begin
    in_sign    = fp_in[63];
    exp_f      = fp_in[62:52];
    frac       = fp_in[51:0];
    frac_zero  = (frac == 52'd0);
    // Only meaningful for e in 52..62, where the left shift is 0..10.
    direct_mag = {11'd0, 1'b1, frac} << 4'(exp_f - EXP_E52);
    // Only meaningful for e < 52; anything past 55 bits collapses into sticky anyway.
    right_dist = EXP_E52 - exp_f;
    cnt_load   = (right_dist > 11'd55) ? 7'd55 : 7'(right_dist);
  end

  // One alignment step: shift right by up to STEP, catching the last bit out as guard.
  always_comb begin
    shift_k      = (cnt_q < STEP) ? cnt_q : STEP;
    out_mask     = (64'd1 << shift_k) - 64'd1;
    shift_work   = work_q >> shift_k;
    shift_guard  = |(work_q & (out_mask ^ (out_mask >> 1)));
    shift_sticky = sticky_q | guard_q | (|(work_q & (out_mask >> 1)));
  end

  // Increment decision for the selected rounding mode.
  always_comb begin
    round_inc = 1'b0;
`ifdef FP2INT_ROUND_MODE_EN
    case (rm_q)
      2'b00:   round_inc = guard_q && (sticky_q || work_q[0]);
      2'b01:   round_inc = 1'b0;
      2'b10:   round_inc = (guard_q || sticky_q) && !sign_q;
      default: round_inc = (guard_q || sticky_q) && sign_q;
    endcase
`else
    round_inc = guard_q && (sticky_q || work_q[0]);
`endif
  end

  // Magnitude never exceeds 2^63-1 here, so negation cannot overflow; -0 negates to 0.
  always_comb begin
    round_mag = work_q + {63'd0, round_inc};
    round_res = sign_q ? (64'd0 - round_mag) : round_mag;
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      int_out      <= 64'd0;
      flag_invalid <= 1'b0;
      flag_inexact <= 1'b0;
      sign_q       <= 1'b0;
      work_q       <= 64'd0;
      cnt_q        <= 7'd0;
      guard_q      <= 1'b0;
      sticky_q     <= 1'b0;
`ifdef FP2INT_ROUND_MODE_EN
      rm_q         <= 2'b00;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            sign_q   <= in_sign;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
`ifdef FP2INT_ROUND_MODE_EN
            rm_q     <= rm;
`endif
            if (exp_f == 11'h7FF) begin
              // NaN always saturates positive; infinities saturate by sign.
              state        <= DONE;
              out_valid    <= 1'b1;
              int_out      <= (!frac_zero || !in_sign) ? POS_SAT : NEG_SAT;
              flag_invalid <= 1'b1;
              flag_inexact <= 1'b0;
            end else if (exp_f == 11'd0) begin
              // Zero and subnormals are below 1 in magnitude.
              state        <= DONE;
              out_valid    <= 1'b1;
              int_out      <= 64'd0;
              flag_invalid <= 1'b0;
              flag_inexact <= !frac_zero;
            end else if (exp_f >= EXP_E63) begin
              // Only exactly -2^63 is representable at or above e=63.
              state        <= DONE;
              out_valid    <= 1'b1;
              flag_inexact <= 1'b0;
              if (in_sign && (exp_f == EXP_E63) && frac_zero) begin
                int_out      <= NEG_SAT;
                flag_invalid <= 1'b0;
              end else begin
                int_out      <= in_sign ? NEG_SAT : POS_SAT;
                flag_invalid <= 1'b1;
              end
            end else if (exp_f >= EXP_E52) begin
              state  <= ROUND;
              work_q <= direct_mag;
            end else begin
              state  <= SHIFT;
              work_q <= {11'd0, 1'b1, frac};
              cnt_q  <= cnt_load;
            end
          end
        end
        SHIFT: begin
          work_q   <= shift_work;
          guard_q  <= shift_guard;
          sticky_q <= shift_sticky;
          cnt_q    <= cnt_q - shift_k;
          if (cnt_q == shift_k) begin
            state <= ROUND;
          end
        end
        ROUND: begin
          state        <= DONE;
          out_valid    <= 1'b1;
          int_out      <= round_res;
          flag_invalid <= 1'b0;
          flag_inexact <= guard_q | sticky_q;
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_to_int64_seq.sv
// tb/tb_fp_to_int64_seq.sv - self-checking bench for fp_to_int64_seq with a value-level reference model
module tb_fp_to_int64_seq;

  localparam int STEP = 8;
  localparam logic [63:0] POS_SAT = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NEG_SAT = 64'h8000_0000_0000_0000;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] fp_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] int_out;
  logic        flag_invalid;
  logic        flag_inexact;
`ifdef FP2INT_ROUND_MODE_EN
  logic [1:0]  rm;
`endif

  int checks = 0;
  int errors = 0;

  fp_to_int64_seq #(.SHIFT_STEP(STEP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .fp_in       (fp_in),
`ifdef FP2INT_ROUND_MODE_EN
    .rm          (rm),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .int_out     (int_out),
    .flag_invalid(flag_invalid),
    .flag_inexact(flag_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Value-level model: the operand is m * 2^(e-52); round to nearest, ties to even.
  task automatic ref_model(input logic [63:0] x, output logic [63:0] r,
                           output logic inv, output logic inx, output int lat);
    logic        s;
    logic [10:0] ef;
    logic [51:0] fr;
    logic [52:0] m;
    logic [127:0] mw, shifted, rem, half;
    logic [63:0] ip, mag;
    logic        up;
    int          e, d, cnt;
    s  = x[63];
    ef = x[62:52];
    fr = x[51:0];
    m  = {1'b1, fr};
    inv = 1'b0;
    inx = 1'b0;
    r   = 64'd0;
    lat = 1;
    if (ef == 11'h7FF) begin
      inv = 1'b1;
      r   = (fr != 0) ? POS_SAT : (s ? NEG_SAT : POS_SAT);
    end else if (ef == 11'd0) begin
      inx = (fr != 0);
    end else begin
      e = int'(ef) - 1023;
      if (e >= 63) begin
        if (!s) begin
          r = POS_SAT; inv = 1'b1;
        end else if (e == 63 && fr == 0) begin
          r = NEG_SAT;
        end else begin
          r = NEG_SAT; inv = 1'b1;
        end
      end else if (e >= 52) begin
        mag = {11'd0, m} << (e - 52);
        r   = s ? -mag : mag;
        lat = 2;
      end else begin
        d = 52 - e;
        if (d >= 55) begin
          ip = 64'd0; up = 1'b0; inx = 1'b1;
        end else begin
          mw      = {75'd0, m};
          shifted = mw >> d;
          ip      = shifted[63:0];
          rem     = mw & ((128'd1 << d) - 128'd1);
          half    = 128'd1 << (d - 1);
          inx     = (rem != 0);
          up      = (rem > half) || ((rem == half) && ip[0]);
        end
        mag = ip + {63'd0, up};
        r   = s ? -mag : mag;
        cnt = (d > 55) ? 55 : d;
        lat = 2 + (cnt + STEP - 1) / STEP;
      end
    end
  endtask

  // Start from #1 after a rising edge with the block idle; ends the same way.
  task automatic run_op(input logic [63:0] x, input int stall, output int lat_seen);
    logic [63:0] er, held;
    logic        einv, einx;
    int          elat;
    ref_model(x, er, einv, einx, elat);
    check("in_ready_idle", {63'd0, in_ready}, 64'd1);
    fp_in    = x;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    fp_in    = {$urandom, $urandom};
    check("in_ready_busy", {63'd0, in_ready}, 64'd0);
    lat_seen = 1;
    while (!out_valid && lat_seen < 300) begin
      @(posedge clk); #1;
      lat_seen++;
    end
    check("out_valid_seen", {63'd0, out_valid}, 64'd1);
    check("latency", 64'(lat_seen), 64'(elat));
    check("int_out", int_out, er);
    check("flag_invalid", {63'd0, flag_invalid}, {63'd0, einv});
    check("flag_inexact", {63'd0, flag_inexact}, {63'd0, einx});
    held = int_out;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_valid", {63'd0, out_valid}, 64'd1);
      check("stall_ready", {63'd0, in_ready}, 64'd0);
      check("stall_int", int_out, held);
      check("stall_flags", {62'd0, flag_invalid, flag_inexact}, {62'd0, einv, einx});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_valid", {63'd0, out_valid}, 64'd0);
    check("post_ready", {63'd0, in_ready}, 64'd1);
  endtask

  logic [63:0] directed [12] = '{
    64'h4059000000000000, 64'h4004000000000000, 64'hC00C000000000000,
    64'h43E0000000000000, 64'hC3E0000000000000, 64'h7FF8000000000000,
    64'h43DFFFFFFFFFFFFF, 64'hC3E0000000000001, 64'h8000000000000000,
    64'hBFD999999999999A, 64'hFFF0000000000000, 64'h4330000000000001
  };

  initial begin
    int          lat;
    int          kind;
    logic [10:0] ef;
    logic [51:0] fr;
    logic [63:0] x;
`ifdef FP2INT_ROUND_MODE_EN
    rm = 2'b00;
`endif
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    fp_in     = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_int_out", int_out, 64'd0);
    check("rst_flags", {62'd0, flag_invalid, flag_inexact}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Test-plan values and range boundaries.
    for (int i = 0; i < 12; i++) begin
      run_op(directed[i], 0, lat);
    end

    // 1.0: fixed latency and a five-cycle stall.
    run_op(64'h3FF0000000000000, 5, lat);
    check("lat_1p0", 64'(lat), 64'd9);

    // Reset while 0.75 is in the shift phase.
    fp_in    = 64'h3FE8000000000000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_int_out", int_out, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(64'h3FE8000000000000, 0, lat);
    run_op(64'h0000000000000001, 0, lat);

    // Randomized operands, weighted towards the shifting and rounding ranges.
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 9);
      fr   = {20'($urandom), $urandom};
      case (kind)
        0:       ef = 11'($urandom);
        1:       ef = 11'h7FF;
        2:       ef = 11'd0;
        3, 4:    ef = 11'($urandom_range(1072, 1090));
        default: begin
          ef = 11'($urandom_range(1010, 1075));
          fr = fr & (52'hF_FFFF_FFFF_FFFF << $urandom_range(0, 52));
        end
      endcase
      if ($urandom_range(0, 7) == 0) fr = 52'd0;
      x = {1'($urandom), ef, fr};
      run_op(x, $urandom_range(0, 2), lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
